// File: rtl/instruction_fetch.sv
// instruction_fetch: IF stage with credit-limited fetch buffer, in-order response capture and redirect squashing
module instruction_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_en,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] jump_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic        inst_valid
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST = PW'(FIFO_DEPTH - 1);
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d, drop_cnt_q, drop_cnt_d, count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [63:0] fifo_q [FIFO_DEPTH];
  logic [63:0] fifo_d [FIFO_DEPTH];
  logic [31:0] inst_q, inst_d, pc_q, pc_d;
  logic inst_valid_q, inst_valid_d;
  logic redirect, pop, accept, resp, push, unused_jump;
  logic [CW:0] credit;
  logic [63:0] head;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == LAST ? '0 : p + PW'(1);
  endfunction
  // handshake decode; an entry leaving the buffer this cycle frees its credit so fetch sustains one per cycle
  always_comb begin
    redirect = clk_en & branch_taken;
    pop = clk_en & ~branch_taken & ~stall & (count_q != '0);
    credit = {1'b0, outstanding_q} + {1'b0, count_q} - (CW + 1)'(pop);
    imem_req = rst_n & clk_en & ~branch_taken & (credit < DEPTH_W);
    imem_addr = fetch_pc_q;
    accept = imem_req & imem_ready;
    resp = imem_rvalid & (outstanding_q != '0);
    push = resp & (drop_cnt_q == '0) & ~redirect;
    head = fifo_q[rd_ptr_q];
    unused_jump = ^jump_addr[1:0];
  end
  // next state: fetch pointer, credit counters, buffer and IF/ID register
  always_comb begin
    fetch_pc_d = redirect ? {jump_addr[31:2], 2'b00} : accept ? fetch_pc_q + 32'd4 : fetch_pc_q;
    outstanding_d = outstanding_q + CW'(accept) - CW'(resp);
    drop_cnt_d = redirect ? outstanding_q - CW'(resp) : (resp && drop_cnt_q != '0) ? drop_cnt_q - CW'(1) : drop_cnt_q;
    fifo_d = fifo_q;
    if (push) fifo_d[wr_ptr_q] = {fetch_pc_q - (32'(outstanding_q) << 2), imem_rdata};
    wr_ptr_d = redirect ? '0 : push ? nxt(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = redirect ? '0 : pop ? nxt(rd_ptr_q) : rd_ptr_q;
    count_d = redirect ? '0 : count_q + CW'(push) - CW'(pop);
    inst_d = redirect ? NOP : (!clk_en || stall) ? inst_q : pop ? head[31:0] : NOP;
    pc_d = pop ? head[63:32] : pc_q;
    inst_valid_d = redirect ? 1'b0 : (!clk_en || stall) ? inst_valid_q : pop;
  end
  // state registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q <= '0;
      count_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fifo_q <= '{default: '0};
      inst_q <= NOP;
      pc_q <= '0;
      inst_valid_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q <= drop_cnt_d;
      count_q <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fifo_q <= fifo_d;
      inst_q <= inst_d;
      pc_q <= pc_d;
      inst_valid_q <= inst_valid_d;
    end
  end
  assign inst = inst_q;
  assign pc = pc_q;
  assign inst_valid = inst_valid_q;
endmodule
